// File: rtl/intersection_scheduler.sv
// Two-road intersection light scheduler with pedestrian walk phase.
// One-second prescaler, per-phase countdown, registered lamp outputs.
module intersection_scheduler #(
  parameter int CLK_FREQ_HZ  = 100,
  parameter int MAIN_GREEN_S = 20,
  parameter int SIDE_GREEN_S = 10,
  parameter int YELLOW_S     = 5,
  parameter int ALL_RED_S    = 2,
  parameter int WALK_S       = 8,
  parameter int PED_CUT_S    = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       side_req,
  input  logic       ped_req,
  output logic [2:0] main_light,
  output logic [2:0] side_light,
  output logic       walk,
  output logic       ped_ack,
  output logic [4:0] sec_left,
  output logic [2:0] phase
);

  localparam logic [2:0] S_MAIN_G = 3'd0;
  localparam logic [2:0] S_MAIN_Y = 3'd1;
  localparam logic [2:0] S_ALL_R1 = 3'd2;
  localparam logic [2:0] S_WALK   = 3'd3;
  localparam logic [2:0] S_SIDE_G = 3'd4;
  localparam logic [2:0] S_SIDE_Y = 3'd5;
  localparam logic [2:0] S_ALL_R2 = 3'd6;

  localparam logic [2:0] L_RED = 3'b100;
  localparam logic [2:0] L_YEL = 3'b010;
  localparam logic [2:0] L_GRN = 3'b001;

  localparam int PW = (CLK_FREQ_HZ > 1) ? $clog2(CLK_FREQ_HZ) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_FREQ_HZ - 1);
  localparam logic [4:0] CUT = 5'(PED_CUT_S);

  logic [2:0]    phase_q, phase_d;
  logic [4:0]    sec_q, sec_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          side_pend_q, side_pend_d;
  logic          ped_pend_q, ped_pend_d;
  logic [2:0]    main_q, main_d;
  logic [2:0]    side_q, side_d;
  logic          walk_q, walk_d;
  logic          ack_q, ack_d;
  logic          tick, last, entering;

  function automatic logic [4:0] dur(input logic [2:0] p);
    logic [4:0] d;
    case (p)
      S_MAIN_Y, S_SIDE_Y: d = 5'(YELLOW_S);
      S_ALL_R1, S_ALL_R2: d = 5'(ALL_RED_S);
      S_WALK:             d = 5'(WALK_S);
      S_SIDE_G:           d = 5'(SIDE_GREEN_S);
      default:            d = 5'(MAIN_GREEN_S);
    endcase
    return d;
  endfunction

  always_comb begin
    tick    = (presc_q == PRESC_MAX);
    last    = tick && (sec_q == 5'd1);
    phase_d = phase_q;
    sec_d   = sec_q;
    presc_d = tick ? '0 : presc_q + 1'b1;
    case (phase_q)
      S_MAIN_G: begin
        // Leave as soon as the count hits zero with someone waiting
        if ((sec_q == 5'd0 || last) && (side_pend_q || ped_pend_q))
          phase_d = S_MAIN_Y;
        else if (ped_req && sec_q > CUT) begin
          sec_d   = CUT;
          presc_d = '0;
        end else if (tick && sec_q != 5'd0)
          sec_d = sec_q - 5'd1;
      end
      S_MAIN_Y: if (last) phase_d = S_ALL_R1;
      S_ALL_R1: if (last) phase_d = ped_pend_q ? S_WALK :
                                    side_pend_q ? S_SIDE_G : S_MAIN_G;
      S_WALK:   if (last) phase_d = side_pend_q ? S_SIDE_G : S_MAIN_G;
      S_SIDE_G: if (last) phase_d = S_SIDE_Y;
      S_SIDE_Y: if (last) phase_d = S_ALL_R2;
      S_ALL_R2: if (last) phase_d = S_MAIN_G;
      default:  phase_d = S_MAIN_G;
    endcase
    if (phase_q != S_MAIN_G && phase_q == phase_d && tick)
      sec_d = sec_q - 5'd1;
    entering = (phase_d != phase_q);
    if (entering) begin
      sec_d   = dur(phase_d);
      presc_d = '0;
    end
  end

  always_comb begin
    side_pend_d = (side_pend_q || (side_req && phase_q != S_SIDE_G))
                  && !(entering && phase_d == S_SIDE_G);
    ped_pend_d  = (ped_pend_q || (ped_req && phase_q != S_WALK))
                  && !(entering && phase_d == S_WALK);
    walk_d = (phase_d == S_WALK);
    ack_d  = entering && (phase_d == S_WALK);
    main_d = L_RED;
    side_d = L_RED;
    unique case (1'b1)
      phase_d == S_MAIN_G: main_d = L_GRN;
      phase_d == S_MAIN_Y: main_d = L_YEL;
      phase_d == S_SIDE_G: side_d = L_GRN;
      phase_d == S_SIDE_Y: side_d = L_YEL;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q     <= S_MAIN_G;
      sec_q       <= 5'(MAIN_GREEN_S);
      presc_q     <= '0;
      side_pend_q <= 1'b0;
      ped_pend_q  <= 1'b0;
      main_q      <= L_GRN;
      side_q      <= L_RED;
      walk_q      <= 1'b0;
      ack_q       <= 1'b0;
    end else begin
      phase_q     <= phase_d;
      sec_q       <= sec_d;
      presc_q     <= presc_d;
      side_pend_q <= side_pend_d;
      ped_pend_q  <= ped_pend_d;
      main_q      <= main_d;
      side_q      <= side_d;
      walk_q      <= walk_d;
      ack_q       <= ack_d;
    end
  end

  assign main_light = main_q;
  assign side_light = side_q;
  assign walk       = walk_q;
  assign ped_ack    = ack_q;
  assign sec_left   = sec_q;
  assign phase      = phase_q;

endmodule

// File: tb/tb_intersection_scheduler.sv
// Directed-vector bench for intersection_scheduler at default parameters.
// Inputs driven and outputs sampled on the falling clock edge.
module tb_intersection_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       side_req = 1'b0;
  logic       ped_req = 1'b0;
  logic [2:0] main_light, side_light;
  logic       walk, ped_ack;
  logic [4:0] sec_left;
  logic [2:0] phase;

  int errors = 0;
  int checks = 0;

  intersection_scheduler dut (
    .clk(clk), .rst(rst), .side_req(side_req), .ped_req(ped_req),
    .main_light(main_light), .side_light(side_light),
    .walk(walk), .ped_ack(ped_ack),
    .sec_left(sec_left), .phase(phase)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic do_reset;
    side_req = 1'b0;
    ped_req  = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_phase(input logic [2:0] p, output int n);
    n = 0;
    while (phase === p && n < 5000) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++; if (phase !== 3'd0) begin errors++; $display("FAIL rst_phase got=%0d exp=0", phase); end
    checks++; if (sec_left !== 5'd20) begin errors++; $display("FAIL rst_sec got=%0d exp=20", sec_left); end
    checks++; if (main_light !== 3'b001) begin errors++; $display("FAIL rst_main got=%b exp=001", main_light); end
    checks++; if (side_light !== 3'b100) begin errors++; $display("FAIL rst_side got=%b exp=100", side_light); end
    checks++; if (walk !== 1'b0 || ped_ack !== 1'b0) begin errors++; $display("FAIL rst_walk_ack got=%b%b exp=00", walk, ped_ack); end
    rst = 1'b0;
    repeat (99) @(negedge clk);
    checks++; if (sec_left !== 5'd20) begin errors++; $display("FAIL presc_99 got=%0d exp=20", sec_left); end
    @(negedge clk);
    checks++; if (sec_left !== 5'd19) begin errors++; $display("FAIL presc_100 got=%0d exp=19", sec_left); end
  endtask

  task automatic test_main_idle;
    do_reset();
    repeat (1999) @(negedge clk);
    checks++; if (sec_left !== 5'd1) begin errors++; $display("FAIL idle_1999 got=%0d exp=1", sec_left); end
    @(negedge clk);
    checks++; if (sec_left !== 5'd0) begin errors++; $display("FAIL idle_2000 got=%0d exp=0", sec_left); end
    repeat (1000) @(negedge clk);
    checks++; if (phase !== 3'd0 || sec_left !== 5'd0) begin errors++; $display("FAIL idle_3000 got=%0d/%0d exp=0/0", phase, sec_left); end
    checks++; if (main_light !== 3'b001) begin errors++; $display("FAIL idle_main got=%b exp=001", main_light); end
  endtask

  task automatic test_side_cycle;
    int n;
    do_reset();
    repeat (300) @(negedge clk);
    side_req = 1'b1;
    run_phase(3'd0, n);
    checks++; if (n + 300 !== 2000) begin errors++; $display("FAIL side_maing_len got=%0d exp=2000", n + 300); end
    checks++; if (phase !== 3'd1 || main_light !== 3'b010 || sec_left !== 5'd5) begin errors++; $display("FAIL side_mainy got=%0d/%b/%0d exp=1/010/5", phase, main_light, sec_left); end
    run_phase(3'd1, n);
    checks++; if (n !== 500) begin errors++; $display("FAIL side_mainy_len got=%0d exp=500", n); end
    checks++; if (phase !== 3'd2 || main_light !== 3'b100 || side_light !== 3'b100) begin errors++; $display("FAIL side_allr1 got=%0d/%b/%b exp=2/100/100", phase, main_light, side_light); end
    run_phase(3'd2, n);
    checks++; if (n !== 200) begin errors++; $display("FAIL side_allr1_len got=%0d exp=200", n); end
    checks++; if (phase !== 3'd4 || side_light !== 3'b001 || main_light !== 3'b100 || sec_left !== 5'd10) begin errors++; $display("FAIL side_sideg got=%0d/%b/%b/%0d exp=4/001/100/10", phase, side_light, main_light, sec_left); end
    run_phase(3'd4, n);
    checks++; if (n !== 1000) begin errors++; $display("FAIL side_sideg_len got=%0d exp=1000", n); end
    checks++; if (phase !== 3'd5 || side_light !== 3'b010) begin errors++; $display("FAIL side_sidey got=%0d/%b exp=5/010", phase, side_light); end
    run_phase(3'd5, n);
    checks++; if (n !== 500) begin errors++; $display("FAIL side_sidey_len got=%0d exp=500", n); end
    run_phase(3'd6, n);
    checks++; if (n !== 200) begin errors++; $display("FAIL side_allr2_len got=%0d exp=200", n); end
    checks++; if (phase !== 3'd0 || sec_left !== 5'd20 || main_light !== 3'b001) begin errors++; $display("FAIL side_back got=%0d/%0d/%b exp=0/20/001", phase, sec_left, main_light); end
    side_req = 1'b0;
  endtask

  task automatic test_ped_cut;
    int n;
    do_reset();
    repeat (599) @(negedge clk);
    ped_req = 1'b1;
    @(negedge clk);
    ped_req = 1'b0;
    checks++; if (sec_left !== 5'd10) begin errors++; $display("FAIL cut_load got=%0d exp=10", sec_left); end
    run_phase(3'd0, n);
    checks++; if (n !== 1000 || phase !== 3'd1) begin errors++; $display("FAIL cut_maing_len got=%0d/%0d exp=1000/1", n, phase); end
    run_phase(3'd1, n);
    run_phase(3'd2, n);
    checks++; if (phase !== 3'd3 || ped_ack !== 1'b1 || walk !== 1'b1 || sec_left !== 5'd8) begin errors++; $display("FAIL cut_walk_entry got=%0d/%b/%b/%0d exp=3/1/1/8", phase, ped_ack, walk, sec_left); end
    checks++; if (main_light !== 3'b100 || side_light !== 3'b100) begin errors++; $display("FAIL cut_walk_lamps got=%b/%b exp=100/100", main_light, side_light); end
    @(negedge clk);
    checks++; if (ped_ack !== 1'b0) begin errors++; $display("FAIL cut_ack_pulse got=%b exp=0", ped_ack); end
    run_phase(3'd3, n);
    checks++; if (n + 1 !== 800) begin errors++; $display("FAIL cut_walk_len got=%0d exp=800", n + 1); end
    checks++; if (phase !== 3'd0 || walk !== 1'b0 || sec_left !== 5'd20) begin errors++; $display("FAIL cut_back got=%0d/%b/%0d exp=0/0/20", phase, walk, sec_left); end
  endtask

  task automatic test_ped_late;
    int n;
    do_reset();
    repeat (1250) @(negedge clk);
    ped_req = 1'b1;
    @(negedge clk);
    ped_req = 1'b0;
    checks++; if (sec_left !== 5'd8) begin errors++; $display("FAIL late_nocut got=%0d exp=8", sec_left); end
    run_phase(3'd0, n);
    checks++; if (n !== 749 || phase !== 3'd1 || sec_left !== 5'd5) begin errors++; $display("FAIL late_exit got=%0d/%0d/%0d exp=749/1/5", n, phase, sec_left); end
  endtask

  task automatic test_ped_boundary;
    do_reset();
    repeat (1050) @(negedge clk);
    ped_req = 1'b1;
    @(negedge clk);
    ped_req = 1'b0;
    checks++; if (sec_left !== 5'd10) begin errors++; $display("FAIL bound_hold got=%0d exp=10", sec_left); end
    repeat (49) @(negedge clk);
    checks++; if (sec_left !== 5'd9) begin errors++; $display("FAIL bound_continue got=%0d exp=9", sec_left); end
  endtask

  task automatic test_back_to_back;
    int n;
    do_reset();
    repeat (10) @(negedge clk);
    side_req = 1'b1;
    @(negedge clk);
    side_req = 1'b0;
    run_phase(3'd0, n);
    checks++; if (n !== 1989 || phase !== 3'd1) begin errors++; $display("FAIL b2b_maing got=%0d/%0d exp=1989/1", n, phase); end
    @(negedge clk);
    side_req = 1'b1;
    ped_req  = 1'b1;
    @(negedge clk);
    side_req = 1'b0;
    ped_req  = 1'b0;
    run_phase(3'd1, n);
    checks++; if (n !== 498 || phase !== 3'd2) begin errors++; $display("FAIL b2b_mainy got=%0d/%0d exp=498/2", n, phase); end
    run_phase(3'd2, n);
    checks++; if (phase !== 3'd3 || ped_ack !== 1'b1) begin errors++; $display("FAIL b2b_walk_first got=%0d/%b exp=3/1", phase, ped_ack); end
    @(negedge clk);
    ped_req = 1'b1;
    @(negedge clk);
    ped_req = 1'b0;
    run_phase(3'd3, n);
    checks++; if (n + 2 !== 800 || phase !== 3'd4) begin errors++; $display("FAIL b2b_walk got=%0d/%0d exp=800/4", n + 2, phase); end
    run_phase(3'd4, n);
    checks++; if (n !== 1000 || phase !== 3'd5) begin errors++; $display("FAIL b2b_sideg got=%0d/%0d exp=1000/5", n, phase); end
    run_phase(3'd5, n);
    run_phase(3'd6, n);
    checks++; if (phase !== 3'd0) begin errors++; $display("FAIL b2b_back got=%0d exp=0", phase); end
    repeat (2100) @(negedge clk);
    checks++; if (phase !== 3'd0 || walk !== 1'b0 || sec_left !== 5'd0) begin errors++; $display("FAIL b2b_walk_ignored got=%0d/%b/%0d exp=0/0/0", phase, walk, sec_left); end
  endtask

  task automatic test_reset_mid_side;
    int n;
    do_reset();
    repeat (10) @(negedge clk);
    side_req = 1'b1;
    @(negedge clk);
    side_req = 1'b0;
    run_phase(3'd0, n);
    run_phase(3'd1, n);
    run_phase(3'd2, n);
    checks++; if (phase !== 3'd4) begin errors++; $display("FAIL mid_reach_sideg got=%0d exp=4", phase); end
    repeat (300) @(negedge clk);
    ped_req = 1'b1;
    @(negedge clk);
    ped_req = 1'b0;
    repeat (100) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (phase !== 3'd0 || sec_left !== 5'd20) begin errors++; $display("FAIL mid_rst got=%0d/%0d exp=0/20", phase, sec_left); end
    checks++; if (main_light !== 3'b001 || side_light !== 3'b100 || walk !== 1'b0) begin errors++; $display("FAIL mid_rst_lamps got=%b/%b/%b exp=001/100/0", main_light, side_light, walk); end
    rst = 1'b0;
    repeat (2500) @(negedge clk);
    checks++; if (phase !== 3'd0 || walk !== 1'b0 || sec_left !== 5'd0) begin errors++; $display("FAIL mid_no_walk got=%0d/%b/%0d exp=0/0/0", phase, walk, sec_left); end
  endtask

  initial begin
    test_reset();
    test_main_idle();
    test_side_cycle();
    test_ped_cut();
    test_ped_late();
    test_ped_boundary();
    test_back_to_back();
    test_reset_mid_side();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/intersection_scheduler.md
INTERSECTION_SCHEDULER -- requirements
Module: intersection_scheduler

Interface
REQ-001 Parameter CLK_FREQ_HZ, default 100, clock cycles per one-second tick.
REQ-002 Parameter MAIN_GREEN_S, default 20, main-road green duration in seconds.
REQ-003 Parameter SIDE_GREEN_S, default 10, side-road green duration in seconds.
REQ-004 Parameter YELLOW_S, default 5, yellow duration in seconds for either road.
REQ-005 Parameter ALL_RED_S, default 2, all-red clearance duration in seconds.
REQ-006 Parameter WALK_S, default 8, pedestrian walk duration in seconds.
REQ-007 Parameter PED_CUT_S, default 10, main-green remaining time after a pedestrian request shortens it.
REQ-008 clk  input  1  single clock; all logic on its rising edge.
REQ-009 rst  input  1  reset, synchronous and active-high.
REQ-010 side_req  input  1  side-road vehicle sensor, level, already synchronized.
REQ-011 ped_req  input  1  debounced pedestrian button, one-cycle pulse, active-high.
REQ-012 main_light  output  3  main-road lamps {red,yellow,green}, one-hot.
REQ-013 side_light  output  3  side-road lamps {red,yellow,green}, one-hot.
REQ-014 walk  output  1  pedestrian walk lamp.
REQ-015 ped_ack  output  1  one-cycle pulse when a pedestrian request is served.
REQ-016 sec_left  output  5  seconds remaining in the current phase, for the seven-segment display.
REQ-017 phase  output  3  state code: MAIN_G=0, MAIN_Y=1, ALL_R1=2, WALK=3, SIDE_G=4, SIDE_Y=5, ALL_R2=6.

Function
REQ-018 The block SHALL generate a one-cycle tick every CLK_FREQ_HZ cycles; the prescaler SHALL restart on every state entry, so each timed state lasts exactly duration*CLK_FREQ_HZ cycles.
REQ-019 The block SHALL load sec_left with the new state's duration on state entry and decrement it on each tick.
REQ-020 Timed states (MAIN_Y, ALL_R1, WALK, SIDE_G, SIDE_Y, ALL_R2) SHALL exit on the tick where sec_left==1.
REQ-021 MAIN_G: sec_left SHALL decrement to 0 and hold there; the state SHALL exit to MAIN_Y on the first cycle where sec_left==0 and either pending flag is set.
REQ-022 Transitions: MAIN_Y->ALL_R1; ALL_R1->WALK if ped_pend, else SIDE_G if side_pend, else MAIN_G; WALK->SIDE_G if side_pend, else MAIN_G; SIDE_G->SIDE_Y->ALL_R2->MAIN_G.
REQ-023 When ped_pend and side_pend are both set at ALL_R1 exit, the block SHALL serve WALK first and then SIDE_G.
REQ-024 side_pend SHALL be set by side_req==1 in any state except SIDE_G, and cleared on SIDE_G entry.
REQ-025 ped_pend SHALL be set by ped_req in any state except WALK, and cleared on WALK entry; ped_req in WALK SHALL be ignored.
REQ-026 ped_ack SHALL pulse for the single cycle in which WALK is entered.
REQ-027 A ped_req in MAIN_G with sec_left>PED_CUT_S SHALL load sec_left=PED_CUT_S on the next cycle; this load SHALL take priority over a same-cycle tick decrement; with sec_left<=PED_CUT_S the countdown SHALL continue unchanged.
REQ-028 Lamps SHALL be: MAIN_G main=001 side=100; MAIN_Y main=010 side=100; SIDE_G main=100 side=001; SIDE_Y main=100 side=010; ALL_R1, ALL_R2, WALK main=100 side=100.
REQ-029 walk SHALL be 1 only in WALK; the two roads SHALL never both show non-red lamps.
REQ-030 All outputs SHALL be registered.

Reset
REQ-031 rst=1 SHALL, on the next clk edge, force MAIN_G, sec_left=MAIN_GREEN_S, main_light=001, side_light=100, walk=0, ped_ack=0, both pending flags cleared, prescaler=0, including mid-phase.

Verification (CLK_FREQ_HZ=100, defaults)
REQ-032 Reset released, no requests for 3000 cycles -> remains MAIN_G, sec_left reaches 0 at cycle 2000 and holds, main_light=001.
REQ-033 side_req=1 held from cycle 300 -> MAIN_G lasts 2000 cycles, MAIN_Y 500, ALL_R1 200, SIDE_G 1000, SIDE_Y 500, ALL_R2 200, then MAIN_G with sec_left=20.
REQ-034 ped_req pulse at sec_left=15 -> sec_left=10 next cycle; MAIN_Y entered 1000 cycles later; after ALL_R1, ped_ack pulses once and walk=1 for 800 cycles; then MAIN_G.
REQ-035 ped_req pulse at sec_left=8 -> sec_left unchanged, countdown continues; MAIN_Y entered when sec_left reaches 0.
REQ-036 side_req and ped_req both asserted during MAIN_Y -> ALL_R1, WALK (800 cycles), SIDE_G (1000 cycles), SIDE_Y, ALL_R2, MAIN_G.
REQ-037 rst pulsed mid-SIDE_G with ped_pend set -> next cycle phase=0, main_light=001, sec_left=20, ped_pend cleared, no WALK follows.
